// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ready handshake and picks next_pc at retire.
// Optional: define FETCH_RETIRE_CNT_EN to add the 32-bit retire_count output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_next;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        retire;

    assign pcplus4       = pc_reg + 32'd4;
    assign branch_target = pcplus4 + {signimm[29:0], 2'b00};
    assign jump_target   = {pcplus4[31:28], instr_reg[25:0], 2'b00};
    assign retire        = (state_reg == EXEC) && !stall;

    // Jump outranks a taken branch when the decoder raises both.
    always_comb begin
        pc_next = pcplus4;
        if (jump) begin
            pc_next = jump_target;
        end else if (pcsrc) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        instr_reg <= imem_rdata;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc_reg    <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count_reg <= 32'd0;
        end else if (retire) begin
            retire_count_reg <= retire_count_reg + 32'd1;
        end
    end

    assign retire_count = retire_count_reg;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    // Handshake outputs come straight from registered state only.
    assign imem_req    = (state_reg == FETCH);
    assign instr_valid = (state_reg == EXEC);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[31:26];
    assign funct       = instr_reg[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait fetch, wait states, stall, branch/jump, wrap, mid-op reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, pcsrc, jump, stall, imem_ready;
    logic [31:0] signimm, imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, pc, pcplus4, instr;
    logic [5:0]  op, funct;

    logic        w_reset;
    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_pc, w_pcplus4, w_instr;
    logic [5:0]  w_op, w_funct;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_count, w_retire_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc),
        .pcplus4(pcplus4), .instr(instr), .op(op), .funct(funct),
        .instr_valid(instr_valid)
`ifdef FETCH_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .pcsrc(1'b0), .jump(1'b0), .signimm(32'd0),
        .stall(1'b0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(32'd0), .imem_ready(1'b1), .pc(w_pc),
        .pcplus4(w_pcplus4), .instr(w_instr), .op(w_op), .funct(w_funct),
        .instr_valid(w_instr_valid)
`ifdef FETCH_RETIRE_CNT_EN
        , .retire_count(w_retire_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; w_reset = 1'b1;
        pcsrc = 1'b0; jump = 1'b0; stall = 1'b0;
        signimm = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;

        tick();
        check("rst_pc",      pc,          32'h0);
        check("rst_pcplus4", pcplus4,     32'h4);
        check("rst_req",     imem_req,    32'd0);
        check("rst_valid",   instr_valid, 32'd0);
        check("rst_op",      op,          32'd0);
        check("rst_funct",   funct,       32'd0);
        tick();
        reset = 1'b0;
        check("rel1_req", imem_req, 32'd0);
        tick();
        check("rel2_req",  imem_req,  32'd1);
        check("rel2_addr", imem_addr, 32'h0);

        // Zero-wait sequential fetch
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        check("seq0_valid", instr_valid, 32'd1);
        check("seq0_op",    op,          32'h08);
        check("seq0_funct", funct,       32'h05);
        check("seq0_pc",    pc,          32'h0);
        tick();
        check("seq1_valid", instr_valid, 32'd0);
        check("seq1_pc",    pc,          32'h4);
        tick();
        check("seq2_valid", instr_valid, 32'd1);
        tick();
        check("seq3_pc",    pc,          32'h8);
        check("seq3_addr",  imem_addr,   32'h8);

        // Wait states
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req",  imem_req,  32'd1);
            check("wait_addr", imem_addr, 32'h8);
        end
        imem_ready = 1'b1; imem_rdata = 32'h8C00_0000;
        tick();
        check("stall0_valid", instr_valid, 32'd1);
        check("stall0_instr", instr,       32'h8C00_0000);

        // Stall two cycles; a stray ready with new data must be ignored
        stall = 1'b1; imem_rdata = 32'hFFFF_FFFF; pcsrc = 1'b1; signimm = 32'h10;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_valid", instr_valid, 32'd1);
            check("stall_pc",    pc,          32'h8);
            check("stall_instr", instr,       32'h8C00_0000);
        end
        stall = 1'b0; pcsrc = 1'b0; signimm = 32'd0;
        tick();
        check("unstall_valid", instr_valid, 32'd0);
        check("unstall_pc",    pc,          32'hC);

        // Advance to pc=0x10
        imem_rdata = 32'h2008_0005;
        tick();
        tick();
        check("at10_pc", pc, 32'h10);

        // Branch to self: 0x14 + (-1 << 2) = 0x10
        imem_rdata = 32'h1000_FFFF;
        tick();
        pcsrc = 1'b1; signimm = 32'hFFFF_FFFF;
        tick();
        check("branch_pc", pc, 32'h10);

        // Jump with pcsrc also high: jump wins -> {0, 0x100, 00} = 0x400
        pcsrc = 1'b0; signimm = 32'd0;
        imem_rdata = 32'h0800_0100;
        tick();
        pcsrc = 1'b1; jump = 1'b1; signimm = 32'h0000_0100;
        tick();
        check("jump_pc", pc, 32'h400);
`ifdef FETCH_RETIRE_CNT_EN
        check("retire_cnt", retire_count, 32'd6);
`endif

        // Reset during EXEC
        pcsrc = 1'b0; jump = 1'b0; signimm = 32'd0;
        imem_rdata = 32'h2008_0005;
        tick();
        check("pre_rst_valid", instr_valid, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_pc",    pc,          32'h0);
        check("midrst_valid", instr_valid, 32'd0);
        check("midrst_req",   imem_req,    32'd0);
        check("midrst_op",    op,          32'd0);
`ifdef FETCH_RETIRE_CNT_EN
        check("midrst_cnt",   retire_count, 32'd0);
`endif
        reset = 1'b0;

        // Wrap: RESET_PC=FFFF_FFFC retires one instruction -> pc=0
        check("wrap_rst_pc",  w_pc,      32'hFFFF_FFFC);
        check("wrap_pcplus4", w_pcplus4, 32'h0);
        w_reset = 1'b0;
        tick();
        check("wrap_fetch_req", w_imem_req, 32'd1);
        tick();
        check("wrap_exec_valid", w_instr_valid, 32'd1);
        tick();
        check("wrap_pc", w_pc, 32'h0);
`ifdef FETCH_RETIRE_CNT_EN
        check("wrap_cnt", w_retire_count, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
